switch_io_ctrl: RTL and testbench

- Memory-mapped switch/button input port on the CPU IO bus; generalised successor of the fixed 16-bit switch reader.
- Parametrised switch width and bus width; adds switch debouncing, a debounced confirm-button FSM, a pending-confirm flag with read-to-clear handshake, and a switch snapshot captured on each confirm.
- Sits between the board pins and the memory/IO read mux; the CPU polls the status register, then reads the snapshot or the live values.

---
 rtl/switch_io_ctrl_if.sv | 8 +
 rtl/switch_io_ctrl.sv | 100 ++++++++++
 tb/tb_switch_io_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/switch_io_ctrl_if.sv
// switch_io_ctrl_if: CPU IO read bus (strobe, address, registered read data).
interface switch_io_ctrl_if #(parameter int DATA_WIDTH = 32);
   logic                  SwitchCtrl;
   logic [31:0]           address;
   logic [DATA_WIDTH-1:0] data_IO_input;
   modport master (output SwitchCtrl, address, input data_IO_input);
   modport slave  (input SwitchCtrl, address, output data_IO_input);
endinterface

// File: rtl/switch_io_ctrl.sv
// switch_io_ctrl: debounced switch/confirm-button IO port with pending flag, snapshot and registered reads.
module switch_io_ctrl #(
   parameter int          SW_WIDTH   = 16,
   parameter int          DATA_WIDTH = 32,
   parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FFF0,
   parameter int          DEB_CYCLES = 20000
) (
   input  logic                clk,
   input  logic                rst,
   switch_io_ctrl_if.slave     bus,
   input  logic [SW_WIDTH-1:0] switch_input,
   input  logic                confirmation,
   output logic                confirm_pulse,
   output logic                confirm_pending
);
   localparam int CW = $clog2(DEB_CYCLES);
   localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES - 1);
   typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
   state_t state_q, state_d;
   logic [SW_WIDTH-1:0] sw_s1_q, sw_s2_q, cand_q, stable_q, stable_d, snap_q, snap_d;
   logic [CW-1:0] dcnt_q, dcnt_d, ccnt_q, ccnt_d;
   logic cf_s1_q, cf_s2_q, pulse_q, pend_q, pend_d, accept, rd_en;
   logic [DATA_WIDTH-1:0] rd_q, rd_d, rd_val;
   logic [31:0] off;
   logic [7:0] top8;
   always_comb begin
      dcnt_d   = (sw_s2_q != cand_q) ? '0 : (dcnt_q == CMAX) ? dcnt_q : dcnt_q + 1'b1;
      stable_d = (sw_s2_q == cand_q && dcnt_q == CMAX) ? cand_q : stable_q;
   end
   // Button counter restarts on every state change; a pulse only on the PRESS_WAIT -> PRESSED edge.
   always_comb begin
      state_d = state_q;
      ccnt_d  = '0;
      accept  = 1'b0;
      case (state_q)
         IDLE:         if (cf_s2_q) state_d = PRESS_WAIT;
         PRESS_WAIT:   if (!cf_s2_q) state_d = IDLE;
                       else if (ccnt_q == CMAX) begin state_d = PRESSED; accept = 1'b1; end
                       else ccnt_d = ccnt_q + 1'b1;
         PRESSED:      if (!cf_s2_q) state_d = RELEASE_WAIT;
         RELEASE_WAIT: if (cf_s2_q) state_d = PRESSED;
                       else if (ccnt_q == CMAX) state_d = IDLE;
                       else ccnt_d = ccnt_q + 1'b1;
         default:      state_d = IDLE;
      endcase
   end
   always_comb begin
      off    = bus.address - BASE_ADDR;
      rd_en  = bus.SwitchCtrl && off < 32'd16;
      top8   = stable_q[SW_WIDTH-1 -: 8];
      rd_val = '0;
      case (off[3:0])
         4'h1: rd_val = DATA_WIDTH'(stable_q);
         4'h3: rd_val = {{(DATA_WIDTH-8){top8[7]}}, top8};
         4'h5: rd_val = DATA_WIDTH'(top8);
         4'h7: rd_val = DATA_WIDTH'(stable_q[2:0]);
         4'h9: rd_val = DATA_WIDTH'(stable_q[7:0]);
         4'hB: rd_val = DATA_WIDTH'(pend_q);
         4'hD: rd_val = DATA_WIDTH'(snap_q);
         default: rd_val = '0;
      endcase
      rd_d   = rd_en ? rd_val : rd_q;
      pend_d = accept | (pend_q & ~(rd_en && off[3:0] == 4'hB));
      snap_d = accept ? stable_q : snap_q;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sw_s1_q  <= '0;
         sw_s2_q  <= '0;
         cf_s1_q  <= 1'b0;
         cf_s2_q  <= 1'b0;
         cand_q   <= '0;
         dcnt_q   <= '0;
         stable_q <= '0;
         snap_q   <= '0;
         state_q  <= IDLE;
         ccnt_q   <= '0;
         pulse_q  <= 1'b0;
         pend_q   <= 1'b0;
         rd_q     <= '0;
      end else begin
         sw_s1_q  <= switch_input;
         sw_s2_q  <= sw_s1_q;
         cf_s1_q  <= confirmation;
         cf_s2_q  <= cf_s1_q;
         cand_q   <= sw_s2_q;
         dcnt_q   <= dcnt_d;
         stable_q <= stable_d;
         snap_q   <= snap_d;
         state_q  <= state_d;
         ccnt_q   <= ccnt_d;
         pulse_q  <= accept;
         pend_q   <= pend_d;
         rd_q     <= rd_d;
      end
   end
   assign bus.data_IO_input = rd_q;
   assign confirm_pulse     = pulse_q;
   assign confirm_pending   = pend_q;
endmodule

// File: tb/tb_switch_io_ctrl.sv
// tb_switch_io_ctrl: scenario tasks plus randomized traffic checked against a run-length reference model.
module tb_switch_io_ctrl;
   localparam int DEB = 4;
   localparam logic [31:0] BASE = 32'hFFFF_FFF0;
   logic clk = 1'b0, rst = 1'b0, cf = 1'b0, pulse, pending;
   logic [15:0] sw = '0;
   int checks = 0, failures = 0;
   always #5 clk = ~clk;
   switch_io_ctrl_if #(.DATA_WIDTH(32)) bus ();
   switch_io_ctrl #(.SW_WIDTH(16), .DATA_WIDTH(32), .BASE_ADDR(BASE), .DEB_CYCLES(DEB)) dut (
      .clk(clk), .rst(rst), .bus(bus), .switch_input(sw), .confirmation(cf),
      .confirm_pulse(pulse), .confirm_pending(pending));

   // Reference: a value is accepted once the synchronised input has shown it for DEB+1 consecutive samples.
   logic [15:0] m_sw1, m_sw2, m_sw_val, m_stable, m_snap;
   logic m_cf1, m_cf2, m_cf_val, m_lvl, m_pending, m_pulse;
   logic [31:0] m_data;
   int m_sw_run, m_cf_run;

   function automatic logic [31:0] expect_read(input logic [3:0] o, input logic [15:0] st,
                                               input logic pend, input logic [15:0] snap);
      case (o)
         4'h1: return {16'h0, st};
         4'h3: return {{24{st[15]}}, st[15:8]};
         4'h5: return {24'h0, st[15:8]};
         4'h7: return {29'h0, st[2:0]};
         4'h9: return {24'h0, st[7:0]};
         4'hB: return {31'h0, pend};
         4'hD: return {16'h0, snap};
         default: return 32'h0;
      endcase
   endfunction

   always @(posedge clk or negedge rst) begin : model
      int swr, cfr;
      logic acc, rel, rd;
      logic [31:0] o;
      if (!rst) begin
         m_sw1 <= '0; m_sw2 <= '0; m_sw_val <= '0; m_stable <= '0; m_snap <= '0;
         m_cf1 <= 1'b0; m_cf2 <= 1'b0; m_cf_val <= 1'b0; m_lvl <= 1'b0;
         m_pending <= 1'b0; m_pulse <= 1'b0; m_data <= '0; m_sw_run <= 1; m_cf_run <= 1;
      end else begin
         swr = (m_sw2 == m_sw_val) ? ((m_sw_run < DEB + 2) ? m_sw_run + 1 : m_sw_run) : 1;
         cfr = (m_cf2 == m_cf_val) ? ((m_cf_run < DEB + 2) ? m_cf_run + 1 : m_cf_run) : 1;
         acc = !m_lvl && m_cf2 && cfr == DEB + 1;
         rel = m_lvl && !m_cf2 && cfr == DEB + 1;
         o = bus.address - BASE;
         rd = bus.SwitchCtrl && o < 32'd16;
         if (rd) m_data <= expect_read(o[3:0], m_stable, m_pending, m_snap);
         if (swr >= DEB + 1) m_stable <= m_sw2;
         if (acc) begin m_lvl <= 1'b1; m_snap <= m_stable; end
         else if (rel) m_lvl <= 1'b0;
         m_pending <= acc || (m_pending && !(rd && o[3:0] == 4'hB));
         m_pulse <= acc;
         m_sw_val <= m_sw2; m_sw_run <= swr; m_cf_val <= m_cf2; m_cf_run <= cfr;
         m_sw1 <= sw; m_sw2 <= m_sw1; m_cf1 <= cf; m_cf2 <= m_cf1;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_read(input logic [3:0] o);
      bus.SwitchCtrl = 1'b1;
      bus.address = BASE + {28'h0, o};
      @(negedge clk);
      bus.SwitchCtrl = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b0; sw = 16'hFFFF; cf = 1'b1;
      cyc(3);
      checks += 3;
      if (bus.data_IO_input !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.data_IO_input); end
      if (pulse !== 1'b0) begin failures++; $display("FAIL reset_pulse got=%b exp=0", pulse); end
      if (pending !== 1'b0) begin failures++; $display("FAIL reset_pending got=%b exp=0", pending); end
      sw = '0; cf = 1'b0;
      rst = 1'b1;
      cyc(8);
   endtask

   task automatic test_switch_read;
      logic [3:0]  offs[5] = '{4'h1, 4'h3, 4'h5, 4'h9, 4'h7};
      logic [31:0] exps[5] = '{32'h0000_A5C3, 32'hFFFF_FFA5, 32'h0000_00A5, 32'h0000_00C3, 32'h0000_0003};
      sw = 16'hA5C3;
      cyc(8);
      for (int i = 0; i < 5; i++) begin
         do_read(offs[i]);
         checks += 2;
         if (bus.data_IO_input !== exps[i]) begin failures++; $display("FAIL read_off%h got=%h exp=%h", offs[i], bus.data_IO_input, exps[i]); end
         if (bus.data_IO_input !== m_data) begin failures++; $display("FAIL read_model_off%h got=%h exp=%h", offs[i], bus.data_IO_input, m_data); end
      end
      bus.address = BASE + 32'h1;
      cyc(2);
      checks++;
      if (bus.data_IO_input !== 32'h3) begin failures++; $display("FAIL hold_no_strobe got=%h exp=3", bus.data_IO_input); end
      bus.SwitchCtrl = 1'b1; bus.address = BASE - 32'h1;
      cyc(1);
      bus.SwitchCtrl = 1'b0;
      checks++;
      if (bus.data_IO_input !== 32'h3) begin failures++; $display("FAIL hold_out_of_window got=%h exp=3", bus.data_IO_input); end
      do_read(4'h1);
      do_read(4'hF);
      checks++;
      if (bus.data_IO_input !== 32'h0) begin failures++; $display("FAIL unmapped_offF got=%h exp=0", bus.data_IO_input); end
   endtask

   task automatic test_glitch;
      sw = 16'h0000; cyc(8);
      sw = 16'h0001; cyc(2);
      sw = 16'h0000; cyc(8);
      do_read(4'h1);
      checks++;
      if (bus.data_IO_input !== 32'h0) begin failures++; $display("FAIL glitch_rejected got=%h exp=0", bus.data_IO_input); end
      sw = 16'h0001; cyc(8);
      do_read(4'h1);
      checks++;
      if (bus.data_IO_input !== 32'h1) begin failures++; $display("FAIL stable_accepted got=%h exp=1", bus.data_IO_input); end
   endtask

   task automatic test_confirm;
      int np = 0;
      sw = 16'h00FF; cyc(8);
      cf = 1'b1; cyc(2); cf = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         np += int'(pulse);
      end
      checks += 2;
      if (np != 0) begin failures++; $display("FAIL short_press_pulses got=%0d exp=0", np); end
      if (pending !== 1'b0) begin failures++; $display("FAIL short_press_pending got=%b exp=0", pending); end
      cf = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (i == 10) cf = 1'b0;
         @(negedge clk);
         np += int'(pulse);
         checks++;
         if (pulse !== m_pulse) begin failures++; $display("FAIL press_pulse_cycle%0d got=%b exp=%b", i, pulse, m_pulse); end
      end
      checks += 2;
      if (np != 1) begin failures++; $display("FAIL long_press_pulses got=%0d exp=1", np); end
      if (pending !== 1'b1) begin failures++; $display("FAIL long_press_pending got=%b exp=1", pending); end
      do_read(4'hD);
      checks++;
      if (bus.data_IO_input !== 32'h0000_00FF) begin failures++; $display("FAIL snapshot got=%h exp=000000ff", bus.data_IO_input); end
   endtask

   task automatic test_handshake;
      do_read(4'hB);
      checks += 2;
      if (bus.data_IO_input !== 32'h1) begin failures++; $display("FAIL status_first got=%h exp=1", bus.data_IO_input); end
      if (pending !== 1'b0) begin failures++; $display("FAIL status_cleared got=%b exp=0", pending); end
      do_read(4'hB);
      checks++;
      if (bus.data_IO_input !== 32'h0) begin failures++; $display("FAIL status_second got=%h exp=0", bus.data_IO_input); end
   endtask

   task automatic test_back_to_back;
      cf = 1'b0; cyc(10);
      cf = 1'b1; cyc(6);
      do_read(4'hB);
      checks += 3;
      if (bus.data_IO_input !== 32'h0) begin failures++; $display("FAIL collide_data got=%h exp=0", bus.data_IO_input); end
      if (pulse !== 1'b1) begin failures++; $display("FAIL collide_pulse got=%b exp=1", pulse); end
      if (pending !== 1'b1) begin failures++; $display("FAIL collide_pending got=%b exp=1", pending); end
      cf = 1'b0; cyc(10);
      do_read(4'hB);
      checks++;
      if (bus.data_IO_input !== 32'h1) begin failures++; $display("FAIL collide_after got=%h exp=1", bus.data_IO_input); end
   endtask

   task automatic test_reset_mid;
      int np = 0;
      do_read(4'h1);
      cf = 1'b1; cyc(8); cf = 1'b0; cyc(10);
      checks += 2;
      if (pending !== 1'b1) begin failures++; $display("FAIL pre_reset_pending got=%b exp=1", pending); end
      if (bus.data_IO_input !== 32'hFF) begin failures++; $display("FAIL pre_reset_data got=%h exp=ff", bus.data_IO_input); end
      cf = 1'b1; cyc(4);
      #2 rst = 1'b0;
      #1;
      checks += 3;
      if (bus.data_IO_input !== 32'h0) begin failures++; $display("FAIL async_reset_data got=%h exp=0", bus.data_IO_input); end
      if (pulse !== 1'b0) begin failures++; $display("FAIL async_reset_pulse got=%b exp=0", pulse); end
      if (pending !== 1'b0) begin failures++; $display("FAIL async_reset_pending got=%b exp=0", pending); end
      cf = 1'b0;
      @(negedge clk) rst = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         checks++;
         if (pulse !== 1'b0) begin failures++; $display("FAIL post_reset_pulse cycle%0d got=%b exp=0", i, pulse); end
      end
      cf = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         np += int'(pulse);
      end
      cf = 1'b0; cyc(10);
      checks++;
      if (np != 1) begin failures++; $display("FAIL fresh_press_pulses got=%0d exp=1", np); end
   endtask

   task automatic test_random;
      int sw_hold = 0, cf_hold = 0;
      for (int i = 0; i < 400; i++) begin
         if (sw_hold == 0) begin sw = 16'($urandom); sw_hold = $urandom_range(1, 10); end else sw_hold--;
         if (cf_hold == 0) begin cf = 1'($urandom); cf_hold = $urandom_range(1, 12); end else cf_hold--;
         bus.SwitchCtrl = ($urandom_range(0, 2) != 0);
         bus.address = ($urandom_range(0, 7) == 0) ? $urandom : BASE + 32'($urandom_range(0, 15));
         @(negedge clk);
         checks += 3;
         if (bus.data_IO_input !== m_data) begin failures++; $display("FAIL rand_data cycle%0d got=%h exp=%h", i, bus.data_IO_input, m_data); end
         if (pulse !== m_pulse) begin failures++; $display("FAIL rand_pulse cycle%0d got=%b exp=%b", i, pulse, m_pulse); end
         if (pending !== m_pending) begin failures++; $display("FAIL rand_pending cycle%0d got=%b exp=%b", i, pending, m_pending); end
      end
      bus.SwitchCtrl = 1'b0;
   endtask

   initial begin
      bus.SwitchCtrl = 1'b0;
      bus.address = '0;
      test_reset();
      test_switch_read();
      test_glitch();
      test_confirm();
      test_handshake();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
